multi_edge_irq: RTL and testbench

- Parametrised, multi-channel successor to the single-bit edge detector, feeding the PL-to-PS interrupt line.
- Per channel: input synchroniser, stable-count glitch filter, rising/falling edge pulses, per-channel edge-mode select and a sticky status bit with clear.
- Produces one aggregated, registered interrupt request for the PS.

---
 rtl/multi_edge_irq.sv | 89 ++++++++
 tb/tb_multi_edge_irq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_irq.sv
// rtl/multi_edge_irq.sv - multi-channel filtered edge detector with sticky status and aggregated irq
module multi_edge_irq #(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     sig_in,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     irq_en,
    input  logic [NUM_CH-1:0]     clr,
    output logic [NUM_CH-1:0]     r_edge,
    output logic [NUM_CH-1:0]     f_edge,
    output logic [NUM_CH-1:0]     status,
    output logic                  irq
);

    localparam int             CW      = $clog2(FILT_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_CYCLES - 1);

    logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
    logic [NUM_CH-1:0] r_filt;
    logic [NUM_CH-1:0] r_filt_q;
    logic [CW-1:0]     r_cnt  [NUM_CH];
    logic [NUM_CH-1:0] w_s;
    logic [NUM_CH-1:0] w_q;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= sig_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Counter saturates at CNT_MAX and commits the new level there, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt   <= '0;
            r_filt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_filt_q <= r_filt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_s[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_filt[i] <= w_s[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_q = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_q[i] = (r_edge[i] & mode[2*i]) | (f_edge[i] & mode[2*i+1]);
        end
    end

    // A qualified edge wins over a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge <= '0;
            f_edge <= '0;
            status <= '0;
            irq    <= 1'b0;
        end else begin
            r_edge <= ~r_filt_q & r_filt;
            f_edge <= r_filt_q & ~r_filt;
            status <= w_q | (status & ~clr);
            irq    <= |(status & irq_en);
        end
    end

endmodule

// File: tb/tb_multi_edge_irq.sv
// tb/tb_multi_edge_irq.sv - scoreboard bench for multi_edge_irq
module tb_multi_edge_irq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sig;
    logic [15:0] mode;
    logic [7:0]  irq_en;
    logic [7:0]  clr;
    logic [7:0]  r_edge_w, f_edge_w, status_w;
    logic        irq_w;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [3:0] chk;
        logic [7:0] r;
        logic [7:0] f;
        logic [7:0] s;
        logic       q;
        string      nm;
    } exp_t;

    typedef struct {
        int         ch;
        logic [1:0] md;
        logic       lvl;
        logic [7:0] xr;
        logic [7:0] xf;
        logic [7:0] xs;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[10];

    multi_edge_irq dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig),
        .mode   (mode),
        .irq_en (irq_en),
        .clr    (clr),
        .r_edge (r_edge_w),
        .f_edge (f_edge_w),
        .status (status_w),
        .irq    (irq_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(string nm, string what, logic [7:0] got, logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s %s at cycle %0d: got %h want %h", nm, what, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        for (int k = sb_q.size() - 1; k >= 0; k--) begin
            if (sb_q[k].cyc == cyc) begin
                if (sb_q[k].chk[0]) cmp(sb_q[k].nm, "r_edge", r_edge_w, sb_q[k].r);
                if (sb_q[k].chk[1]) cmp(sb_q[k].nm, "f_edge", f_edge_w, sb_q[k].f);
                if (sb_q[k].chk[2]) cmp(sb_q[k].nm, "status", status_w, sb_q[k].s);
                if (sb_q[k].chk[3]) cmp(sb_q[k].nm, "irq", {7'd0, irq_w}, {7'd0, sb_q[k].q});
                sb_q.delete(k);
            end
        end
    end

    task automatic push(int c, logic [3:0] chk, logic [7:0] r, logic [7:0] f,
                        logic [7:0] s, logic q, string nm);
        exp_t e;
        e.cyc = c; e.chk = chk; e.r = r; e.f = f; e.s = s; e.q = q; e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        clr = 8'hFF;
        tick(1);
        clr = 8'h00;
        tick(1);
    endtask

    initial begin
        int t;
        vt[0] = '{1, 2'b10, 1'b0, 8'h00, 8'h02, 8'h02};
        vt[1] = '{1, 2'b10, 1'b1, 8'h02, 8'h00, 8'h00};
        vt[2] = '{1, 2'b10, 1'b0, 8'h00, 8'h02, 8'h02};
        vt[3] = '{4, 2'b00, 1'b0, 8'h00, 8'h10, 8'h00};
        vt[4] = '{4, 2'b00, 1'b1, 8'h10, 8'h00, 8'h00};
        vt[5] = '{5, 2'b11, 1'b0, 8'h00, 8'h20, 8'h20};
        vt[6] = '{5, 2'b11, 1'b1, 8'h20, 8'h00, 8'h20};
        vt[7] = '{6, 2'b01, 1'b0, 8'h00, 8'h40, 8'h00};
        vt[8] = '{6, 2'b01, 1'b1, 8'h40, 8'h00, 8'h40};
        vt[9] = '{7, 2'b01, 1'b0, 8'h00, 8'h80, 8'h00};

        rst = 1'b1; sig = 8'hFF; mode = 16'h5555; irq_en = 8'hFF; clr = 8'h00;
        for (int c = 1; c <= 3; c++) push(c, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, "reset");
        push(9,  4'b0111, 8'h00, 8'h00, 8'h00, 1'b0, "rst_rel_pre");
        push(10, 4'b0111, 8'hFF, 8'h00, 8'h00, 1'b0, "rst_rel_edge");
        push(11, 4'b1111, 8'h00, 8'h00, 8'hFF, 1'b0, "rst_rel_status");
        push(12, 4'b1100, 8'h00, 8'h00, 8'hFF, 1'b1, "rst_rel_irq");
        tick(3);
        rst = 1'b0;
        tick(9);
        push(cyc + 1, 4'b0100, 8'h00, 8'h00, 8'h00, 1'b0, "clr_all_status");
        push(cyc + 2, 4'b1000, 8'h00, 8'h00, 8'h00, 1'b0, "clr_all_irq");
        clear_all();
        irq_en = 8'h00;
        tick(2);

        for (int v = 0; v < 10; v++) begin
            t = cyc;
            mode[2*vt[v].ch +: 2] = vt[v].md;
            sig[vt[v].ch] = vt[v].lvl;
            push(t + 6, 4'b0011, 8'h00, 8'h00, 8'h00, 1'b0, $sformatf("vec%0d_pre", v));
            push(t + 7, 4'b0011, vt[v].xr, vt[v].xf, 8'h00, 1'b0, $sformatf("vec%0d_edge", v));
            push(t + 8, 4'b0111, 8'h00, 8'h00, vt[v].xs, 1'b0, $sformatf("vec%0d_status", v));
            tick(9);
            clear_all();
        end

        mode[1:0] = 2'b11;
        sig[0] = 1'b0;
        tick(12);
        clear_all();
        t = cyc;
        for (int c = 1; c <= 14; c++) push(t + c, 4'b0111, 8'h00, 8'h00, 8'h00, 1'b0, "glitch3");
        sig[0] = 1'b1;
        tick(3);
        sig[0] = 1'b0;
        tick(12);

        t = cyc;
        push(t + 6,  4'b0011, 8'h00, 8'h00, 8'h00, 1'b0, "pulse4_pre");
        push(t + 7,  4'b0011, 8'h01, 8'h00, 8'h00, 1'b0, "pulse4_rise");
        push(t + 8,  4'b0111, 8'h00, 8'h00, 8'h01, 1'b0, "pulse4_after_rise");
        push(t + 10, 4'b0011, 8'h00, 8'h00, 8'h00, 1'b0, "pulse4_pre_fall");
        push(t + 11, 4'b0011, 8'h00, 8'h01, 8'h00, 1'b0, "pulse4_fall");
        push(t + 12, 4'b0011, 8'h00, 8'h00, 8'h00, 1'b0, "pulse4_after_fall");
        sig[0] = 1'b1;
        tick(4);
        sig[0] = 1'b0;
        tick(12);
        clear_all();

        sig[2] = 1'b0;
        tick(12);
        clear_all();
        t = cyc;
        push(t + 7,  4'b0001, 8'h04, 8'h00, 8'h00, 1'b0, "race_edge");
        push(t + 8,  4'b1100, 8'h00, 8'h00, 8'h04, 1'b0, "race_set_wins");
        push(t + 9,  4'b1100, 8'h00, 8'h00, 8'h00, 1'b1, "race_clr_only");
        push(t + 10, 4'b1100, 8'h00, 8'h00, 8'h00, 1'b0, "race_irq_drop");
        sig[2] = 1'b1; clr = 8'h04; irq_en = 8'hFF;
        tick(10);
        clr = 8'h00;
        tick(2);

        t = cyc;
        push(t + 7, 4'b0011, 8'h00, 8'h0C, 8'h00, 1'b0, "mask_fall");
        push(t + 8, 4'b0100, 8'h00, 8'h00, 8'h0C, 1'b0, "mask_status");
        push(t + 9, 4'b1100, 8'h00, 8'h00, 8'h0C, 1'b1, "mask_irq_on");
        mode[7:4] = 4'b1111; irq_en = 8'h04; sig[3:2] = 2'b00;
        tick(9);
        push(cyc + 1, 4'b1100, 8'h00, 8'h00, 8'h0C, 1'b0, "mask_irq_off");
        irq_en = 8'h00;
        tick(2);
        clear_all();

        sig = 8'h00;
        tick(12);
        clear_all();
        t = cyc;
        sig[3] = 1'b1;
        tick(4);
        push(t + 5, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, "midrst_in_reset");
        push(t + 6, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, "midrst_in_reset");
        rst = 1'b1; sig[3] = 1'b0;
        tick(2);
        rst = 1'b0;
        t = cyc;
        for (int c = 1; c <= 12; c++) push(t + c, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, "midrst_quiet");
        tick(14);
        t = cyc;
        push(t + 6, 4'b0001, 8'h00, 8'h00, 8'h00, 1'b0, "midrst_restart_pre");
        push(t + 7, 4'b0001, 8'h08, 8'h00, 8'h00, 1'b0, "midrst_restart_edge");
        push(t + 8, 4'b0001, 8'h00, 8'h00, 8'h00, 1'b0, "midrst_restart_post");
        sig[3] = 1'b1;
        tick(12);

        while (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL unchecked %s: scheduled cycle %0d, now %0d", sb_q[0].nm, sb_q[0].cyc, cyc);
            void'(sb_q.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
